// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared frame constants, FSM state type and DIN helper for the
//            ADC SPI sampler.
// Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int LEAD_ZEROS = 4;
  localparam int DATA_BITS  = 12;
  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int ADDR_POS   = 2;
  localparam int ADDR_BITS  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Level driven on DIN during bit-period idx: the mux address sits MSB first
  // starting at ADDR_POS, every other position is zero.
  function automatic logic mosi_bit(input logic [ADDR_BITS-1:0] addr,
                                    input logic [3:0]           idx);
    int         k;
    logic [1:0] sel;
    logic       res;
    res = 1'b0;
    sel = 2'd0;
    k   = int'(idx) - ADDR_POS;
    if (k >= 0 && k < ADDR_BITS) begin
      sel = 2'(ADDR_BITS - 1 - k);
      res = addr[sel];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : adc_rate_gen
// Purpose  : Sample-rate counter; one-cycle tick every SAMPLE_PERIOD clocks
//            while enabled, parked at zero while disabled.
// Revision : 1.0 - initial release
// ============================================================================
module adc_rate_gen
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int                 c_cnt_w = $clog2(SAMPLE_PERIOD);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SAMPLE_PERIOD - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;
  logic               w_wrap;

  assign w_wrap = (cnt_q == c_last);
  assign o_tick = i_en & w_wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_en || w_wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_sampler
// Purpose  : Periodically reads one channel of a 16-clock-frame 12-bit SPI
//            ADC and presents the sample with a one-cycle ready strobe.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 8,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int CHANNEL       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 soc,
  input  logic                 adc_miso,
  output logic                 adc_sclk,
  output logic                 adc_cs_n,
  output logic                 adc_mosi,
  output logic [DATA_BITS-1:0] adc_data,
  output logic                 adc_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int                   c_cnt_w      = $clog2(CLK_DIV + 1);
  localparam logic [c_cnt_w-1:0]   c_half_last  = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0]   c_setup_last = c_cnt_w'(CLK_DIV);
  localparam logic [3:0]           c_bit_last   = 4'(FRAME_BITS - 1);
  localparam logic [ADDR_BITS-1:0] c_addr       = ADDR_BITS'(CHANNEL);

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic                 w_tick;
  logic                 w_start;

  adc_rate_gen #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_rate_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (en),
    .o_tick (w_tick)
  );

  assign w_start = w_tick | soc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    // DONE counts as occupied: a start there is dropped, not queued.
    if (w_start && state_q != IDLE) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b1;
        end
      end

      // One cycle longer than a half-period so CS-to-SCLK setup always
      // exceeds CLK_DIV and the CS window totals 34*CLK_DIV+1 cycles.
      SETUP: begin
        if (cnt_q == c_setup_last) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = mosi_bit(c_addr, 4'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q == c_half_last) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Leading zeros fall off the top after the full 16 shifts.
            sclk_d  = 1'b1;
            shift_d = {shift_q[DATA_BITS-2:0], adc_miso};
          end else if (bit_q == c_bit_last) begin
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b0;
            mosi_d = mosi_bit(c_addr, bit_q + 4'd1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == c_half_last) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          mosi_d  = 1'b0;
          data_d  = shift_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_sclk  = sclk_q;
  assign adc_cs_n  = cs_n_q;
  assign adc_mosi  = mosi_q;
  assign adc_data  = data_q;
  assign adc_ready = ready_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_sampler
// Purpose  : Scoreboard bench for adc_spi_sampler with a behavioural ADC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_sampler;

  localparam int CLK_DIV       = 8;
  localparam int SAMPLE_PERIOD = 2500;
  localparam int CHANNEL       = 5;
  localparam int FRAME_LAT     = 34 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        soc = 1'b0;
  logic        adc_miso = 1'b0;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        adc_mosi;
  logic [11:0] adc_data;
  logic        adc_ready;
  logic        busy;
  logic        overrun;

  adc_spi_sampler #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .CHANNEL       (CHANNEL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .soc       (soc),
    .adc_miso  (adc_miso),
    .adc_sclk  (adc_sclk),
    .adc_cs_n  (adc_cs_n),
    .adc_mosi  (adc_mosi),
    .adc_data  (adc_data),
    .adc_ready (adc_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ADC model state: one conversion value per frame, in frame order.
  logic [11:0] vals [64];
  int          mdl_idx = 0;
  logic [15:0] frame_w;
  int          bitn;
  logic [11:0] exp_q [$];

  // Monitor state
  int          cyc = 0;
  int          fall_cyc = 0;
  int          low_cnt = 0;
  int          rises = 0;
  int          frames = 0;
  int          n_ready = 0;
  int          last_ready_cyc = 0;
  bit          in_frame = 1'b0;
  bit          prev_cs = 1'b1;
  bit          prev_sclk = 1'b1;
  bit          prev_ready = 1'b0;
  bit          spaced_last = 1'b0;
  bit          chk_spacing = 1'b0;
  logic [11:0] last_data = '0;
  logic [11:0] e_val;
  logic [15:0] mosi_seen = '0;
  logic [15:0] mosi_exp;
  logic [2:0]  ch3;

  // Stimulus scratch
  logic [11:0] dvals [3] = '{12'h000, 12'h800, 12'h001};
  int          snap_frames;
  int          snap_ready;

  // Behavioural ADC: DOUT changes on each SCLK falling edge, MSB first,
  // 4 zero bits then the 12-bit conversion.
  task model();
    forever begin
      @(negedge adc_cs_n);
      frame_w = {4'h0, vals[mdl_idx]};
      exp_q.push_back(vals[mdl_idx]);
      mdl_idx = (mdl_idx + 1) % 64;
      bitn = 0;
      while (bitn < 16) begin
        @(negedge adc_sclk or posedge adc_cs_n);
        if (adc_cs_n) break;
        adc_miso = frame_w[15 - bitn];
        bitn++;
      end
      if (!adc_cs_n) @(posedge adc_cs_n);
      adc_miso = 1'b0;
    end
  endtask

  task monitor();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        exp_q.delete();
        last_data   = '0;
        in_frame    = 1'b0;
        prev_cs     = 1'b1;
        prev_sclk   = 1'b1;
        prev_ready  = 1'b0;
        spaced_last = 1'b0;
      end else begin
        if (!adc_cs_n && prev_cs) begin
          in_frame = 1'b1;
          fall_cyc = cyc;
          low_cnt  = 0;
          rises    = 0;
          frames++;
        end
        if (!adc_cs_n) begin
          low_cnt++;
          if (adc_sclk && !prev_sclk) begin
            if (rises < 16) mosi_seen[15 - rises] = adc_mosi;
            rises++;
          end
        end
        if (adc_cs_n && !prev_cs && in_frame) begin
          check("cs_low_cycles", low_cnt, FRAME_LAT);
          check("sclk_rises", rises, 16);
          check("mosi_frame", {16'd0, mosi_seen}, {16'd0, mosi_exp});
          in_frame = 1'b0;
        end
        if (adc_ready) begin
          check("ready_double", {31'd0, prev_ready}, 0);
          check("ready_latency", cyc - fall_cyc, FRAME_LAT);
          if (exp_q.size() == 0) begin
            check("sb_nonempty", exp_q.size(), 1);
          end else begin
            e_val = exp_q.pop_front();
            check("adc_data", {20'd0, adc_data}, {20'd0, e_val});
            last_data = e_val;
          end
          if (chk_spacing && spaced_last) check("ready_spacing", cyc - last_ready_cyc, SAMPLE_PERIOD);
          spaced_last    = chk_spacing;
          last_ready_cyc = cyc;
          n_ready++;
        end else begin
          check("data_hold", {20'd0, adc_data}, {20'd0, last_data});
        end
        prev_cs    = adc_cs_n;
        prev_sclk  = adc_sclk;
        prev_ready = adc_ready;
      end
    end
  endtask

  task automatic pulse_soc();
    soc = 1'b1;
    @(negedge clk);
    soc = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!adc_ready && n < budget);
    check(tag, {31'd0, adc_ready}, 1);
  endtask

  task automatic wait_cs_fall(input int budget);
    int n = 0;
    while (adc_cs_n && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("cs_fall_seen", {31'd0, adc_cs_n}, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) vals[i] = 12'($urandom);
    ch3 = 3'(CHANNEL);
    mosi_exp = '0;
    for (int k = 0; k < 16; k++) begin
      if (k >= 2 && k <= 4) mosi_exp[15 - k] = ch3[4 - k];
    end
    fork
      monitor();
      model();
    join_none

    // Reset state
    idle(3);
    check("rst_sclk", {31'd0, adc_sclk}, 1);
    check("rst_cs_n", {31'd0, adc_cs_n}, 1);
    check("rst_mosi", {31'd0, adc_mosi}, 0);
    check("rst_data", {20'd0, adc_data}, 0);
    check("rst_ready", {31'd0, adc_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    idle(5);

    // Single soc with en low, full-scale sample
    vals[mdl_idx] = 12'hFFF;
    pulse_soc();
    check("busy_in_frame", {31'd0, busy}, 1);
    wait_ready(FRAME_LAT + 50, "ready_fff");
    check("overrun_single", {31'd0, overrun}, 0);
    idle(50);

    // Boundary codes separated by idle gaps
    for (int i = 0; i < 3; i++) begin
      vals[mdl_idx] = dvals[i];
      pulse_soc();
      wait_ready(FRAME_LAT + 50, "ready_code");
      idle(30 + int'($urandom_range(0, 60)));
      check("data_after_idle", {20'd0, adc_data}, {20'd0, dvals[i]});
    end

    // Periodic sampling: three 0xABC frames then random codes
    vals[mdl_idx]            = 12'hABC;
    vals[(mdl_idx + 1) % 64] = 12'hABC;
    vals[(mdl_idx + 2) % 64] = 12'hABC;
    chk_spacing = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) wait_ready(SAMPLE_PERIOD + 400, "ready_periodic");
    en = 1'b0;
    chk_spacing = 1'b0;
    snap_frames = frames;
    idle(SAMPLE_PERIOD + 100);
    check("no_tick_en_low", frames, snap_frames);

    // Start in the cycle after DONE is accepted
    pulse_soc();
    wait_ready(FRAME_LAT + 50, "ready_pre_after_done");
    @(negedge clk);
    pulse_soc();
    check("accept_after_done", {31'd0, adc_cs_n}, 0);
    wait_ready(FRAME_LAT + 50, "ready_after_done");
    check("overrun_after_done", {31'd0, overrun}, 0);
    idle(20);

    // soc 100 cycles into a frame
    pulse_soc();
    wait_cs_fall(10);
    idle(100);
    snap_frames = frames;
    pulse_soc();
    check("overrun_mid_frame", {31'd0, overrun}, 1);
    check("busy_mid_frame", {31'd0, busy}, 1);
    wait_ready(FRAME_LAT, "ready_overrun_frame");
    idle(400);
    check("no_second_frame", frames, snap_frames);
    check("overrun_sticky", {31'd0, overrun}, 1);

    // Reset in the middle of SHIFT
    pulse_soc();
    wait_cs_fall(10);
    idle(100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", {31'd0, adc_cs_n}, 1);
    check("abort_sclk", {31'd0, adc_sclk}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_data", {20'd0, adc_data}, 0);
    check("abort_ready", {31'd0, adc_ready}, 0);
    check("abort_mosi", {31'd0, adc_mosi}, 0);
    check("abort_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    snap_ready = n_ready;
    idle(FRAME_LAT + 20);
    check("no_ready_after_abort", n_ready, snap_ready);
    en = 1'b1;
    wait_ready(SAMPLE_PERIOD + 400, "ready_after_reset");

    // Start arriving in the DONE cycle is an overrun
    en  = 1'b0;
    snap_frames = frames;
    pulse_soc();
    check("overrun_done_cycle", {31'd0, overrun}, 1);
    idle(50);
    check("no_frame_from_done", frames, snap_frames);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d vectors, expected completion", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
